assoc_wb_cache: RTL and testbench
=================================

Name: assoc_wb_cache

Overview:
- Parametrised set-associative, write-back, write-allocate cache. It succeeds the fixed direct-mapped instruction/data caches.
- Sits between the pipelined datapath (word-wide request side) and line-wide instruction or data memory. Memory has fixed latency and no acknowledge.
- Adds configurable sets, ways and line size, LRU replacement, dirty-line write-back and hit/miss counters.

Parameters:
- WORD_SIZE, 16, data and address word width.
- NUM_SETS, 4, number of sets; power of two, at least 1.
- NUM_WAYS, 2, associativity; 1 or 2.
- LINE_WORDS, 4, words per line; power of two; memory bus is LINE_WORDS*WORD_SIZE bits.
- MEM_LATENCY, 4, cycles a memory strobe is held per line transfer; at least 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- read_cache  in  1  word read request.
- write_cache  in  1  word write request.
- address_cache  in  WORD_SIZE  word address.
- wdata_cache  in  WORD_SIZE  store data.
- rdata_cache  out  WORD_SIZE  load data; valid when ready is high for a read.
- ready  out  1  request completes this cycle; datapath stalls while a request is high and ready is low.
- readM  out  1  memory line read strobe.
- writeM  out  1  memory line write strobe.
- address_memory  out  WORD_SIZE  line base address; offset bits are zero.
- mem_rdata  in  LINE_WORDS*WORD_SIZE  line from memory.
- mem_wdata  out  LINE_WORDS*WORD_SIZE  victim line to memory.
- hit_count  out  16  saturating count of hits.
- miss_count  out  16  saturating count of misses.

Behaviour:
- Address split: offset = log2(LINE_WORDS) LSBs, index = next log2(NUM_SETS) bits, tag = remaining bits. Each way holds valid, dirty, tag and line; each set holds one LRU bit.
- Reset: all valid, dirty and LRU bits cleared; both counters 0; state IDLE; readM=0, writeM=0, ready=0, address_memory=0, mem_wdata=0, rdata_cache=0.
- Reset mid-operation: the transfer is abandoned, strobes drop at that edge and no line is installed.
- IDLE, hit: ready=1 combinationally in the same cycle.
  - Read: rdata_cache = selected word.
  - Write: the word is updated and dirty set at the edge.
  - LRU points to the other way; hit_count increments.
  - Zero-stall hit.
- IDLE, miss: ready=0, miss_count increments once, and the victim is chosen.
  - Victim order: first invalid way (way 0 first), otherwise the LRU way.
  - Dirty victim goes to WRITEBACK; otherwise to REFILL.
- WRITEBACK: writeM=1 for exactly MEM_LATENCY cycles.
  - address_memory = {victim tag, index, 0}; mem_wdata = victim line.
  - Then REFILL.
- REFILL: readM=1 for exactly MEM_LATENCY cycles.
  - address_memory = {request tag, index, 0}.
  - On the last cycle mem_rdata is written into the victim way: valid=1, dirty=0, tag updated.
  - Then IDLE, where the request re-evaluates as a hit.
- Strobes are registered. readM and writeM are never high together, and each drops for at least 1 cycle between phases.
- Miss penalty, measured from the request cycle to the ready cycle:
  - Clean victim: MEM_LATENCY+1.
  - Dirty victim: 2*MEM_LATENCY+1.
  - The completing hit is also counted in hit_count.
- Request rules:
  - Address and data are held stable until ready.
  - If the request drops during a miss, the fill still completes and the cache returns to IDLE.
  - read_cache and write_cache both high is treated as a write.
  - No request in IDLE: ready=0 and no state change.
- Counters saturate at 16'hFFFF.
- NUM_WAYS=1: LRU unused; the single way is always the victim.

Test Plan:
- Cold read: reset, read 0x0012 → readM=1 with address_memory 0x0010 for 4 cycles; mem_rdata words {A0,A1,A2,A3}; ready at cycle 5 with rdata_cache=A2; miss_count=1, hit_count=1.
- Hit path: then read 0x0011 → ready same cycle, rdata_cache=A1, no strobe; hit_count=2.
- Write hit plus eviction:
  - Write 0x0013=BEEF → ready same cycle.
  - Fill 0x0050 into way 1, then touch 0x0010 (LRU→way 1) and 0x0050 (LRU→way 0).
  - Read 0x0090 → writeM=1, address_memory 0x0010, word 3 of mem_wdata=BEEF for 4 cycles; then readM on 0x0090; ready at cycle 9.
- LRU: sets with lines 0x0010 and 0x0050; read 0x0010, then miss 0x0090 → way holding 0x0050 replaced; a later read of 0x0010 hits.
- Reset during REFILL: assert reset on cycle 2 of a fill → strobes 0 next cycle, counters 0, and re-reading the same address misses again.
- Dropped request / both strobes: drop read_cache mid-fill → fill completes, returns to IDLE, ready stays 0; read and write together on a hit → write performed.

Source files
------------

// File: rtl/assoc_wb_cache.sv
// Set-associative write-back, write-allocate cache between a word-wide datapath
// and a fixed-latency line-wide memory, with LRU replacement and hit/miss counters.
module assoc_wb_cache #(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_SETS    = 4,
    parameter int NUM_WAYS    = 2,
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            read_cache,
    input  logic                            write_cache,
    input  logic [WORD_SIZE-1:0]            address_cache,
    input  logic [WORD_SIZE-1:0]            wdata_cache,
    output logic [WORD_SIZE-1:0]            rdata_cache,
    output logic                            ready,
    output logic                            readM,
    output logic                            writeM,
    output logic [WORD_SIZE-1:0]            address_memory,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
    output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int OFF_B  = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_B  = (IDX_W > 0) ? IDX_W : 1;
    localparam int LINE_W = LINE_WORDS * WORD_SIZE;
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                readm_q, readm_d, writem_q, writem_d;
    logic [WORD_SIZE-1:0] addr_mem_q, addr_mem_d;
    logic [LINE_W-1:0]   wdata_mem_q, wdata_mem_d;
    logic [15:0]         hit_cnt_q, miss_cnt_q;
    logic                victim_q, victim_d;
    logic [TAG_W-1:0]    m_tag_q, m_tag_d;
    logic [IDX_B-1:0]    m_idx_q, m_idx_d;

    logic                valid_q [NUM_WAYS][NUM_SETS];
    logic                dirty_q [NUM_WAYS][NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]   data_q  [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    logic                req;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_B-1:0]    req_idx;
    logic [OFF_B-1:0]    req_off;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit, hit_way, victim, victim_dirty;
    logic [LINE_W-1:0]   hit_line;
    logic                do_hit, do_write, do_fill, do_miss;

    assign req     = read_cache | write_cache;
    assign req_tag = address_cache[WORD_SIZE-1 -: TAG_W];
    assign req_idx = IDX_B'((address_cache >> OFF_W) & WORD_SIZE'(NUM_SETS - 1));
    assign req_off = OFF_B'(address_cache & WORD_SIZE'(LINE_WORDS - 1));

    function automatic logic [WORD_SIZE-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                       input logic [IDX_B-1:0] i);
        line_addr = (WORD_SIZE'(t) << (OFF_W + IDX_W))
                  | ((WORD_SIZE'(i) << OFF_W) & WORD_SIZE'((NUM_SETS - 1) << OFF_W));
    endfunction

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
    end

    assign hit      = |hit_vec;
    assign hit_way  = (NUM_WAYS > 1) ? hit_vec[NUM_WAYS-1] : 1'b0;
    assign hit_line = data_q[hit_way][req_idx];

    // Victim: first invalid way (way 0 first), otherwise the LRU way.
    always_comb begin
        victim = 1'b0;
        if (NUM_WAYS > 1) begin
            if (!valid_q[0][req_idx])
                victim = 1'b0;
            else if (!valid_q[NUM_WAYS-1][req_idx])
                victim = 1'b1;
            else
                victim = lru_q[req_idx];
        end
    end
    assign victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        readm_d     = readm_q;
        writem_d    = writem_q;
        addr_mem_d  = addr_mem_q;
        wdata_mem_d = wdata_mem_q;
        victim_d    = victim_q;
        m_tag_d     = m_tag_q;
        m_idx_d     = m_idx_q;
        ready       = 1'b0;
        rdata_cache = '0;
        do_hit      = 1'b0;
        do_write    = 1'b0;
        do_fill     = 1'b0;
        do_miss     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !reset) begin
                    if (hit) begin
                        ready    = 1'b1;
                        do_hit   = 1'b1;
                        do_write = write_cache;
                        if (!write_cache)
                            rdata_cache = hit_line[req_off*WORD_SIZE +: WORD_SIZE];
                    end else begin
                        do_miss  = 1'b1;
                        victim_d = victim;
                        m_tag_d  = req_tag;
                        m_idx_d  = req_idx;
                        cnt_d    = '0;
                        if (victim_dirty) begin
                            state_d     = WRITEBACK;
                            writem_d    = 1'b1;
                            addr_mem_d  = line_addr(tag_q[victim][req_idx], req_idx);
                            wdata_mem_d = data_q[victim][req_idx];
                        end else begin
                            state_d    = REFILL;
                            readm_d    = 1'b1;
                            addr_mem_d = line_addr(req_tag, req_idx);
                        end
                    end
                end
            end
            WRITEBACK: begin
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    state_d    = REFILL;
                    writem_d   = 1'b0;
                    readm_d    = 1'b1;
                    cnt_d      = '0;
                    addr_mem_d = line_addr(m_tag_q, m_idx_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REFILL: begin
                if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    state_d = IDLE;
                    readm_d = 1'b0;
                    do_fill = !reset;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            readm_q     <= 1'b0;
            writem_q    <= 1'b0;
            addr_mem_q  <= '0;
            wdata_mem_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            victim_q    <= 1'b0;
            m_tag_q     <= '0;
            m_idx_q     <= '0;
            lru_q       <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readm_q     <= readm_d;
            writem_q    <= writem_d;
            addr_mem_q  <= addr_mem_d;
            wdata_mem_q <= wdata_mem_d;
            victim_q    <= victim_d;
            m_tag_q     <= m_tag_d;
            m_idx_q     <= m_idx_d;
            if (do_hit && hit_cnt_q != 16'hFFFF)
                hit_cnt_q <= hit_cnt_q + 16'd1;
            if (do_miss && miss_cnt_q != 16'hFFFF)
                miss_cnt_q <= miss_cnt_q + 16'd1;
            if (do_hit) begin
                // The LRU bit names the least-recently-used way of the set.
                if (NUM_WAYS > 1)
                    lru_q[req_idx] <= ~hit_way;
                if (do_write)
                    dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (do_fill) begin
                valid_q[victim_q][m_idx_q] <= 1'b1;
                dirty_q[victim_q][m_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and line storage carry no reset; validity alone decides whether they are used.
    always_ff @(posedge clk) begin
        if (do_write)
            data_q[hit_way][req_idx][req_off*WORD_SIZE +: WORD_SIZE] <= wdata_cache;
        if (do_fill) begin
            data_q[victim_q][m_idx_q] <= mem_rdata;
            tag_q[victim_q][m_idx_q]  <= m_tag_q;
        end
    end

    assign readM          = readm_q;
    assign writeM         = writem_q;
    assign address_memory = addr_mem_q;
    assign mem_wdata      = wdata_mem_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache: a word-level golden memory gives expected
// load data, a line-level backing store plays the fixed-latency memory.
module tb_assoc_wb_cache;
    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        reset, read_cache, write_cache;
    logic [15:0] address_cache, wdata_cache, rdata_cache;
    logic        ready, readM, writeM;
    logic [15:0] address_memory;
    logic [63:0] mem_rdata, mem_wdata;
    logic [15:0] hit_count, miss_count;

    always #5 clk = ~clk;

    assoc_wb_cache #(
        .WORD_SIZE(16), .NUM_SETS(4), .NUM_WAYS(2), .LINE_WORDS(4), .MEM_LATENCY(ML)
    ) dut (
        .clk(clk), .reset(reset), .read_cache(read_cache), .write_cache(write_cache),
        .address_cache(address_cache), .wdata_cache(wdata_cache), .rdata_cache(rdata_cache),
        .ready(ready), .readM(readM), .writeM(writeM), .address_memory(address_memory),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    logic [15:0] backing [0:1023];
    logic [15:0] gold    [0:1023];

    always_comb begin
        mem_rdata = '0;
        for (int w = 0; w < 4; w++)
            mem_rdata[w*16 +: 16] = backing[{address_memory[9:2], 2'(w)}];
    end

    typedef struct {
        bit          is_read;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] gold_line(input logic [15:0] a);
        logic [63:0] l;
        for (int w = 0; w < 4; w++)
            l[w*16 +: 16] = gold[{a[9:2], 2'(w)}];
        return l;
    endfunction

    task automatic check_counters();
        chk("hit_count", 64'(hit_count), 64'(exp_hits));
        chk("miss_count", 64'(miss_count), 64'(exp_misses));
    endtask

    // One request held until ready; exp_lat is request-cycle to ready-cycle.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input int exp_lat,
                          input logic [15:0] wb_addr);
        exp_t e;
        int   cyc, rd_cyc, wr_cyc;
        bit   done;
        @(negedge clk);
        read_cache    = rd;
        write_cache   = wr;
        address_cache = addr;
        wdata_cache   = data;
        e.is_read = rd && !wr;
        e.data    = gold[addr[9:0]];
        if (wr) gold[addr[9:0]] = data;
        sb.push_back(e);
        cyc = 0; rd_cyc = 0; wr_cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            chk("strobe_excl", 64'(readM && writeM), 64'd0);
            if (readM) begin
                rd_cyc++;
                chk("refill_addr", 64'(address_memory), 64'(addr & 16'hFFFC));
            end
            if (writeM) begin
                wr_cyc++;
                chk("wb_addr", 64'(address_memory), 64'(wb_addr));
                chk("wb_data", mem_wdata, gold_line(wb_addr));
                for (int w = 0; w < 4; w++)
                    backing[{address_memory[9:2], 2'(w)}] = mem_wdata[w*16 +: 16];
            end
            if (ready) begin
                done = 1'b1;
                e = sb.pop_front();
                if (e.is_read) chk("rdata", 64'(rdata_cache), 64'(e.data));
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) begin
            chk("ready_timeout", 64'(ready), 64'd1);
            sb.delete();
        end
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("refill_cycles", 64'(rd_cyc), 64'((exp_lat == 0) ? 0 : ML));
        chk("wb_cycles", 64'(wr_cyc), 64'((exp_lat == 2*ML+1) ? ML : 0));
        if (exp_lat == 0) exp_hits++;
        else begin exp_misses++; exp_hits++; end
        $display("txn rd=%0d wr=%0d addr=%h wdata=%h lat=%0d rdata=%h", rd, wr, addr, data, cyc, rdata_cache);
        @(negedge clk);
        read_cache  = 1'b0;
        write_cache = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; read_cache = 1'b0; write_cache = 1'b0;
        address_cache = '0; wdata_cache = '0;
        for (int a = 0; a < 1024; a++) begin
            backing[a] = 16'hA000 | 16'(a);
            gold[a]    = 16'hA000 | 16'(a);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_readM", 64'(readM), 64'd0);
        chk("rst_writeM", 64'(writeM), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_addr_mem", 64'(address_memory), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", 64'(rdata_cache), 64'd0);
        check_counters();
        reset = 1'b0;

        // Cold miss, hits, write hit, second way fill, LRU touches, dirty eviction.
        do_req(1, 0, 16'h0012, 16'h0000, 5, 16'h0000);
        check_counters();
        do_req(1, 0, 16'h0011, 16'h0000, 0, 16'h0000);
        do_req(0, 1, 16'h0013, 16'hBEEF, 0, 16'h0000);
        do_req(1, 0, 16'h0050, 16'h0000, 5, 16'h0000);
        do_req(1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
        do_req(1, 0, 16'h0050, 16'h0000, 0, 16'h0000);
        do_req(1, 0, 16'h0090, 16'h0000, 9, 16'h0010);
        chk("backing_beef", 64'(backing[10'h013]), 64'h0000_0000_0000_BEEF);
        check_counters();

        // Written-back data returns from memory; LRU picks the older line.
        do_req(1, 0, 16'h0013, 16'h0000, 5, 16'h0000);
        do_req(1, 0, 16'h0050, 16'h0000, 5, 16'h0000);
        do_req(1, 0, 16'h0010, 16'h0000, 0, 16'h0000);
        do_req(1, 0, 16'h0090, 16'h0000, 5, 16'h0000);
        do_req(1, 0, 16'h0012, 16'h0000, 0, 16'h0000);
        check_counters();

        // Reset in the second refill cycle abandons the fill.
        @(negedge clk);
        read_cache = 1'b1; address_cache = 16'h0024;
        #1 chk("rstmid_ready", 64'(ready), 64'd0);
        @(negedge clk);
        #1 chk("rstmid_readM_on", 64'(readM), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_readM", 64'(readM), 64'd0);
        chk("rstmid_writeM", 64'(writeM), 64'd0);
        chk("rstmid_ready_off", 64'(ready), 64'd0);
        exp_hits = 0; exp_misses = 0;
        check_counters();
        reset = 1'b0; read_cache = 1'b0;
        do_req(1, 0, 16'h0024, 16'h0000, 5, 16'h0000);
        check_counters();

        // Request dropped mid-fill: fill completes silently, line is then resident.
        @(negedge clk);
        read_cache = 1'b1; address_cache = 16'h0034;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) read_cache = 1'b0;
            #1;
            if (readM) n++;
            if (i >= 2) chk("drop_no_ready", 64'(ready), 64'd0);
        end
        chk("drop_fill_cycles", 64'(n), 64'(ML));
        exp_misses++;
        $display("txn dropped read addr=0034 fill_cycles=%0d", n);
        do_req(1, 0, 16'h0034, 16'h0000, 0, 16'h0000);

        // Read and write together act as a write.
        do_req(1, 1, 16'h0035, 16'h1234, 0, 16'h0000);
        do_req(1, 0, 16'h0035, 16'h0000, 0, 16'h0000);
        check_counters();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
